alien_march_controller: RTL and testbench

ALIEN_MARCH_CONTROLLER -- requirements
Module: alien_march_controller

---
 rtl/chip_invaders_pkg.sv | 17 +
 rtl/alive_popcount.sv | 17 +
 rtl/alien_march_controller.sv | 196 +++++++++++++++++++
 tb/tb_alien_march_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_invaders_pkg.sv
// Shared types and screen defaults for the alien march controller.
package chip_invaders_pkg;

  // Formation movement states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH   = 3'd1,
    DESCEND = 3'd2,
    CLEARED = 3'd3,
    LANDED  = 3'd4
  } march_state_t;

  // Default horizontal playfield bounds in pixels.
  localparam int DEFAULT_SCREEN_LEFT  = 16;
  localparam int DEFAULT_SCREEN_RIGHT = 624;

endpackage

// File: rtl/alive_popcount.sv
// Combinational population count of the flattened alive flags.
module alive_popcount #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [7:0]       count_o
);

  // Sum every alive flag into an 8-bit count.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + 8'(bits_i[i]);
    end
  end

endmodule

// File: rtl/alien_march_controller.sv
// Alien formation march controller: paces horizontal steps from frame ticks,
// drops the formation a row at each screen edge, and reports clear/landed.
// Optional speedup (period shrinks with fewer live aliens) is enabled by
// defining CHIPINV_MARCH_SPEEDUP_EN; otherwise the period stays BASE_PERIOD.
// Current FSM state is exported on state_dbg.
module alien_march_controller
  import chip_invaders_pkg::*;
#(
  parameter int NUM_ROWS         = 3,
  parameter int NUM_COLS         = 5,
  parameter int SCREEN_LEFT      = DEFAULT_SCREEN_LEFT,
  parameter int SCREEN_RIGHT     = DEFAULT_SCREEN_RIGHT,
  parameter int STEP_X           = 4,
  parameter int BASE_PERIOD      = 100,
  parameter int MIN_PERIOD       = 4,
  parameter int PERIOD_PER_ALIEN = 6,
  parameter int MAX_DESCENDS     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_tick,
  input  logic                               enable,
  input  logic                               next_wave,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  alive_matrix,
  input  logic [15:0]                        formation_min_x,
  input  logic [15:0]                        formation_max_x,
  output logic                               movement_direction,
  output logic [15:0]                        movement_frequency,
  output logic                               step_pulse,
  output logic                               descend_pulse,
  output logic [7:0]                         alive_count,
  output logic                               wave_cleared,
  output logic                               invaded,
  output logic [2:0]                         state_dbg
);

  localparam int NUM_ALIENS = NUM_ROWS * NUM_COLS;

  logic [NUM_ALIENS-1:0] alive_flat;
  logic [7:0]            pop_count;

  march_state_t state_q, state_d;
  logic         dir_q, dir_d;
  logic [15:0]  freq_q, freq_d;
  logic [15:0]  tick_q, tick_d;
  logic [7:0]   desc_cnt_q, desc_cnt_d;
  logic [7:0]   alive_q, alive_d;
  logic         step_q, step_d;
  logic         desc_q, desc_d;
  logic         clr_q, clr_d;
  logic         inv_q, inv_d;
  logic         step_event;
  logic         edge_hit;

  assign alive_flat = alive_matrix;

  alive_popcount #(.WIDTH(NUM_ALIENS)) u_alive_popcount (
    .bits_i  (alive_flat),
    .count_o (pop_count)
  );

  // A step is due once tick_cnt has reached period-1 (written as +1 to avoid underflow).
  assign step_event = ({1'b0, tick_q} + 17'd1) >= {1'b0, freq_q};

  // Would one more step in the current direction leave the legal x range?
  assign edge_hit = dir_q ? ((32'(formation_max_x) + 32'(STEP_X)) > 32'(SCREEN_RIGHT))
                          : (32'(formation_min_x) < 32'(SCREEN_LEFT + STEP_X));

`ifdef CHIPINV_MARCH_SPEEDUP_EN
  logic [31:0] period_wide;

  // Next alive count and a period that shrinks as aliens die, saturated and floored.
  always_comb begin
    alive_d     = pop_count;
    period_wide = 32'(MIN_PERIOD) + 32'(alive_q) * 32'(PERIOD_PER_ALIEN);
    if (period_wide > 32'h0000_FFFF) begin
      freq_d = 16'hFFFF;
    end else if (period_wide < 32'(MIN_PERIOD)) begin
      freq_d = 16'(MIN_PERIOD);
    end else begin
      freq_d = period_wide[15:0];
    end
  end
`else
  // Next alive count; the march period stays fixed.
  always_comb begin
    alive_d = pop_count;
    freq_d  = 16'(BASE_PERIOD);
  end
`endif

  // Next-state and pulse logic; an empty formation overrides everything but LANDED.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tick_d     = tick_q;
    desc_cnt_d = desc_cnt_q;
    step_d     = 1'b0;
    desc_d     = 1'b0;
    if (state_q != LANDED && alive_q == 8'd0) begin
      state_d = CLEARED;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = MARCH;
        end
        MARCH: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (frame_tick) begin
            if (step_event) begin
              tick_d = '0;
              if (edge_hit) begin
                desc_d  = 1'b1;
                state_d = DESCEND;
              end else begin
                step_d = 1'b1;
              end
            end else begin
              tick_d = tick_q + 16'd1;
            end
          end
        end
        DESCEND: begin
          dir_d      = ~dir_q;
          desc_cnt_d = desc_cnt_q + 8'd1;
          if ((32'(desc_cnt_q) + 32'd1) >= 32'(MAX_DESCENDS)) begin
            state_d = LANDED;
          end else begin
            state_d = MARCH;
          end
        end
        CLEARED: begin
          if (next_wave) begin
            state_d    = MARCH;
            tick_d     = '0;
            desc_cnt_d = '0;
            dir_d      = 1'b1;
          end
        end
        LANDED: begin
          state_d = LANDED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    clr_d = (state_d == CLEARED);
    inv_d = (state_d == LANDED);
  end

  // Register alive count and march period.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q <= '0;
      freq_q  <= 16'(BASE_PERIOD);
    end else begin
      alive_q <= alive_d;
      freq_q  <= freq_d;
    end
  end

  // Register FSM state, counters and all status/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b1;
      tick_q     <= '0;
      desc_cnt_q <= '0;
      step_q     <= 1'b0;
      desc_q     <= 1'b0;
      clr_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tick_q     <= tick_d;
      desc_cnt_q <= desc_cnt_d;
      step_q     <= step_d;
      desc_q     <= desc_d;
      clr_q      <= clr_d;
      inv_q      <= inv_d;
    end
  end

  assign movement_direction = dir_q;
  assign movement_frequency = freq_q;
  assign step_pulse         = step_q;
  assign descend_pulse      = desc_q;
  assign alive_count        = alive_q;
  assign wave_cleared       = clr_q;
  assign invaded            = inv_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_alien_march_controller.sv
// Bench for alien_march_controller: reset, directed corner sequences, a
// popcount/period vector table, and a randomized run against a reference model.
module tb_alien_march_controller;
  import chip_invaders_pkg::*;

`ifdef CHIPINV_MARCH_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam int BASE   = 100;
  localparam int P_FULL = SPEEDUP ? 94 : 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_tick = 1'b0;
  logic             enable = 1'b0;
  logic             next_wave = 1'b0;
  logic [2:0][4:0]  alive_matrix = '1;
  logic [15:0]      formation_min_x = 16'd200;
  logic [15:0]      formation_max_x = 16'd400;
  logic             movement_direction;
  logic [15:0]      movement_frequency;
  logic             step_pulse;
  logic             descend_pulse;
  logic [7:0]       alive_count;
  logic             wave_cleared;
  logic             invaded;
  logic [2:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  alien_march_controller dut (
    .clk                (clk),
    .rst                (rst),
    .frame_tick         (frame_tick),
    .enable             (enable),
    .next_wave          (next_wave),
    .alive_matrix       (alive_matrix),
    .formation_min_x    (formation_min_x),
    .formation_max_x    (formation_max_x),
    .movement_direction (movement_direction),
    .movement_frequency (movement_frequency),
    .step_pulse         (step_pulse),
    .descend_pulse      (descend_pulse),
    .alive_count        (alive_count),
    .wave_cleared       (wave_cleared),
    .invaded            (invaded),
    .state_dbg          (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver helpers
  task automatic start_wave();
    cyc();
    cyc();
    next_wave = 1'b1;
    cyc();
    next_wave = 1'b0;
  endtask

  task automatic wait_pulse(input bit want_desc, input int limit, output int n);
    n = 0;
    while (((want_desc ? descend_pulse : step_pulse) !== 1'b1) && n < limit) begin
      cyc();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL wait_pulse: no %s pulse within %0d cycles", want_desc ? "descend" : "step", limit);
    end
  endtask

  task automatic count_to_land(input int limit, output int descs, output int steps);
    int n;
    n = 0;
    descs = 0;
    steps = 0;
    while (invaded !== 1'b1 && n < limit) begin
      cyc();
      n++;
      if (descend_pulse === 1'b1) descs++;
      if (step_pulse === 1'b1) steps++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    chk({tag, "_dir"}, 32'(movement_direction), 32'd1);
    chk({tag, "_freq"}, 32'(movement_frequency), 32'(BASE));
    chk({tag, "_pulses"}, {30'd0, step_pulse, descend_pulse}, 32'd0);
    chk({tag, "_count"}, 32'(alive_count), 32'd0);
    chk({tag, "_flags"}, {30'd0, wave_cleared, invaded}, 32'd0);
  endtask

  // Reference model: spec rules over plain integers, updated once per clock.
  localparam int M_IDLE = 0, M_MARCH = 1, M_DESC = 2, M_CLR = 3, M_LAND = 4;
  int m_mode, m_tick, m_hits, m_cnt, m_freq;
  bit m_dir, m_step, m_desc;

  function automatic int period_of(input int n);
    int p;
    if (!SPEEDUP) return BASE;
    p = 4 + n * 6;
    if (p > 65535) p = 65535;
    if (p < 4) p = 4;
    return p;
  endfunction

  task automatic model_cycle(input bit r, input bit ft, input bit en, input bit nw,
                             input logic [14:0] am, input int minx, input int maxx);
    int new_cnt, new_freq;
    bit hit;
    if (r) begin
      m_mode = M_IDLE; m_dir = 1'b1; m_freq = BASE; m_tick = 0; m_hits = 0;
      m_cnt = 0; m_step = 1'b0; m_desc = 1'b0;
      return;
    end
    new_cnt  = $countones(am);
    new_freq = period_of(m_cnt);
    m_step = 1'b0;
    m_desc = 1'b0;
    if (m_mode != M_LAND && m_cnt == 0) begin
      m_mode = M_CLR;
    end else if (m_mode == M_IDLE) begin
      if (en) m_mode = M_MARCH;
    end else if (m_mode == M_MARCH) begin
      if (!en) m_mode = M_IDLE;
      else if (ft) begin
        if (m_tick >= m_freq - 1) begin
          m_tick = 0;
          hit = m_dir ? (maxx + 4 > 624) : (minx < 16 + 4);
          if (hit) begin
            m_desc = 1'b1;
            m_mode = M_DESC;
          end else begin
            m_step = 1'b1;
          end
        end else begin
          m_tick++;
        end
      end
    end else if (m_mode == M_DESC) begin
      m_dir = !m_dir;
      m_hits++;
      m_mode = (m_hits >= 8) ? M_LAND : M_MARCH;
    end else if (m_mode == M_CLR) begin
      if (nw) begin
        m_mode = M_MARCH; m_tick = 0; m_hits = 0; m_dir = 1'b1;
      end
    end
    m_cnt  = new_cnt;
    m_freq = new_freq;
  endtask

  typedef struct {
    logic [14:0] mat;
    int          cnt;
    int          freq_on;
  } vec_t;

  initial begin
    int n, n2, n3, descs, steps, seen;
    vec_t vecs[8];
    bit r, ft, en, nw;
    logic [14:0] am;
    int minx, maxx;
    int xl[3];
    int xr[3];

    vecs[0] = '{15'h7FFF, 15, 94};
    vecs[1] = '{15'h0001, 1, 10};
    vecs[2] = '{15'h0000, 0, 4};
    vecs[3] = '{15'h4000, 1, 10};
    vecs[4] = '{15'h5555, 8, 52};
    vecs[5] = '{15'h7C00, 5, 34};
    vecs[6] = '{15'h001F, 5, 34};
    vecs[7] = '{15'h2108, 3, 22};
    xl = '{19, 20, 200};
    xr = '{620, 621, 400};

    // Reset values while rst is held, even with inputs active
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b1; alive_matrix = '1;
    cyc();
    cyc();
    chk_reset_outputs("reset");

    // Empty count right after reset forces CLEARED until next_wave
    rst = 1'b0;
    cyc();
    chk("post_reset_cleared", 32'(wave_cleared), 32'd1);
    chk("post_reset_count", 32'(alive_count), 32'd15);
    cyc();
    chk("full_period", 32'(movement_frequency), 32'(P_FULL));
    next_wave = 1'b1;
    cyc();
    next_wave = 1'b0;
    chk("next_wave_march", 32'(state_dbg), 32'(MARCH));
    chk("next_wave_flag", 32'(wave_cleared), 32'd0);

    // Step cadence: one step per period of frame ticks
    wait_pulse(1'b0, 3 * P_FULL, n);
    cyc();
    wait_pulse(1'b0, 3 * P_FULL, n2);
    chk("step_interval", 32'(n2 + 1), 32'(P_FULL));
    for (int i = 0; i < 5; i++) cyc();
    frame_tick = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    frame_tick = 1'b1;
    wait_pulse(1'b0, 3 * P_FULL, n3);
    chk("step_interval_gap", 32'(15 + n3), 32'(P_FULL + 10));

    // enable low parks in IDLE, high resumes marching
    enable = 1'b0;
    cyc();
    cyc();
    chk("enable_low_idle", 32'(state_dbg), 32'(IDLE));
    enable = 1'b1;
    cyc();
    chk("enable_high_march", 32'(state_dbg), 32'(MARCH));

    // Reset while in DESCEND drops the pending direction toggle
    formation_max_x = 16'd622;
    wait_pulse(1'b1, 3 * P_FULL, n);
    chk("desc_state", 32'(state_dbg), 32'(DESCEND));
    chk("desc_no_step", 32'(step_pulse), 32'd0);
    rst = 1'b1;
    cyc();
    chk_reset_outputs("rst_in_descend");
    rst = 1'b0;
    start_wave();

    // Right edge at max_x=622: one descend pulse, then direction flips
    wait_pulse(1'b1, 3 * P_FULL, n);
    chk("edge_desc_pulse", 32'(descend_pulse), 32'd1);
    chk("edge_no_step", 32'(step_pulse), 32'd0);
    chk("edge_dir_before", 32'(movement_direction), 32'd1);
    cyc();
    chk("edge_dir_after", 32'(movement_direction), 32'd0);
    chk("edge_pulses_after", {30'd0, step_pulse, descend_pulse}, 32'd0);
    chk("edge_back_march", 32'(state_dbg), 32'(MARCH));

    // Both edges hit: eighth descend lands the formation
    formation_min_x = 16'd10;
    count_to_land(10 * P_FULL + 50, descs, steps);
    chk("land_descends", 32'(descs + 1), 32'd8);
    chk("land_no_steps", 32'(steps), 32'd0);
    chk("land_invaded", 32'(invaded), 32'd1);
    seen = 0;
    alive_matrix = '0;
    for (int i = 0; i < 2 * P_FULL; i++) begin
      next_wave = (i % 7 == 0);
      cyc();
      if (step_pulse !== 1'b0 || descend_pulse !== 1'b0 || invaded !== 1'b1 || wave_cleared !== 1'b0) seen++;
    end
    next_wave = 1'b0;
    chk("landed_hold", 32'(seen), 32'd0);
    chk("landed_state", 32'(state_dbg), 32'(LANDED));

    // Clear coinciding with a step event: CLEARED wins, no pulse
    alive_matrix = '1;
    formation_min_x = 16'd200;
    formation_max_x = 16'd622;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    start_wave();
    wait_pulse(1'b1, 3 * P_FULL, n);
    formation_max_x = 16'd400;
    wait_pulse(1'b0, 3 * P_FULL, n);
    for (int i = 0; i < P_FULL - 2; i++) cyc();
    alive_matrix = '0;
    cyc();
    chk("clr_pre_count", 32'(alive_count), 32'd0);
    chk("clr_pre_pulses", {30'd0, step_pulse, descend_pulse}, 32'd0);
    cyc();
    chk("clr_no_pulse", {30'd0, step_pulse, descend_pulse}, 32'd0);
    chk("clr_flag", 32'(wave_cleared), 32'd1);
    chk("clr_dir_left", 32'(movement_direction), 32'd0);
    alive_matrix = '1;
    cyc();
    cyc();
    next_wave = 1'b1;
    cyc();
    next_wave = 1'b0;
    chk("rewave_state", 32'(state_dbg), 32'(MARCH));
    chk("rewave_dir", 32'(movement_direction), 32'd1);
    chk("rewave_flag", 32'(wave_cleared), 32'd0);
    formation_min_x = 16'd10;
    formation_max_x = 16'd622;
    count_to_land(10 * P_FULL + 50, descs, steps);
    chk("rewave_full_descends", 32'(descs), 32'd8);

    // Popcount and period vector table
    foreach (vecs[i]) begin
      alive_matrix = vecs[i].mat;
      cyc();
      cyc();
      chk("tbl_count", 32'(alive_count), 32'(vecs[i].cnt));
      chk("tbl_freq", 32'(movement_frequency), 32'(SPEEDUP ? vecs[i].freq_on : BASE));
    end

    // Randomized run against the reference model
    am = 15'h7FFF;
    minx = 200;
    maxx = 400;
    for (int c = 0; c < 5000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 999) == 0);
      ft = ($urandom_range(0, 9) != 0);
      en = ($urandom_range(0, 29) != 0);
      nw = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) am = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        minx = xl[$urandom_range(0, 2)];
        maxx = xr[$urandom_range(0, 2)];
      end
      rst = r; frame_tick = ft; enable = en; next_wave = nw; alive_matrix = am;
      formation_min_x = 16'(minx); formation_max_x = 16'(maxx);
      model_cycle(r, ft, en, nw, am, minx, maxx);
      cyc();
      chk("rand_outputs",
          {3'd0, movement_direction, step_pulse, descend_pulse, wave_cleared, invaded, alive_count, movement_frequency},
          {3'd0, m_dir, m_step, m_desc, (m_mode == M_CLR), (m_mode == M_LAND), 8'(m_cnt), 16'(m_freq)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
